// File: rtl/regfile_scoreboarded.sv
// Multi-port integer register file with x0 hardwired to zero, optional
// write-to-read bypass and a per-register busy scoreboard for long-latency writes.
module regfile_scoreboarded #(
  parameter int NUM_REGS  = 32,
  parameter int XLEN      = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int BYPASS    = 1,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(NUM_REGS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic [NUM_WRITE-1:0]      wr_en,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_addr,
  output logic [CW-1:0]             busy_count
);

  logic [XLEN-1:0]     regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0]     regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] busy_d;
  logic [CW-1:0]       count_d;
  logic                busy_clr;

  // Ascending port scan: the highest-index enabled writer wins.
  always_comb begin
    busy_clr = 1'b0;
    busy_d   = busy_q;
    count_d  = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      busy_clr  = 1'b0;
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) begin
          regs_d[r] = wr_data[j*XLEN +: XLEN];
          busy_clr  = 1'b1;
        end
      end
      // A fresh issue supersedes a completing writeback.
      if (iss_en && iss_addr == AW'(r))
        busy_d[r] = 1'b1;
      else if (busy_clr)
        busy_d[r] = 1'b0;
      count_d = count_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < NUM_REGS; r++)
        regs_q[r] <= '0;
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++)
        regs_q[r] <= regs_d[r];
      busy_q     <= busy_d;
      busy_count <= count_d;
    end
  end

  // Read outputs are forced to zero while reset is held so bypassed write data cannot leak out.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (rd_addr[i*AW +: AW] == AW'(r)) begin
          rd_data[i*XLEN +: XLEN] = regs_q[r];
          rd_busy[i]              = busy_q[r];
        end
      end
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW] &&
              rd_addr[i*AW +: AW] != '0) begin
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            rd_busy[i]              = 1'b0;
          end
        end
      end
      if (!rst_n) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboarded.sv
// Directed bench: one DUT with bypass enabled and one without, driven by identical stimulus.
module tb_regfile_scoreboarded;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] b_rd_data, n_rd_data;
  logic [1:0]  b_rd_busy, n_rd_busy;
  logic [5:0]  b_count,   n_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] b_d0, b_d1, n_d0, n_d1;
  assign b_d0 = b_rd_data[31:0];
  assign b_d1 = b_rd_data[63:32];
  assign n_d0 = n_rd_data[31:0];
  assign n_d1 = n_rd_data[63:32];

  regfile_scoreboarded #(
    .NUM_REGS(32), .XLEN(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_count(b_count)
  );

  regfile_scoreboarded #(
    .NUM_REGS(32), .XLEN(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(n_rd_data),
    .rd_busy(n_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_count(n_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    #2;
    checks++; if (b_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", b_count); end
    checks++; if (b_rd_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", b_rd_data); end
    checks++; if (b_rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", b_rd_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle();
    rd_addr = {5'd7, 5'd5};
    #1;
    checks++; if (b_d0 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_x5: got %h expected deadbeef", b_d0); end
    checks++; if (b_rd_busy[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy_x7: got %b expected 1", b_rd_busy[1]); end
    checks++; if (b_count !== 6'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", b_count); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (b_d0 !== 32'd0) begin errors++; $display("FAIL midreset_x5: got %h expected 0", b_d0); end
    checks++; if (b_rd_busy[1] !== 1'b0) begin errors++; $display("FAIL midreset_busy_x7: got %b expected 0", b_rd_busy[1]); end
    checks++; if (b_count !== 6'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", b_count); end
    checks++; if (n_count !== 6'd0) begin errors++; $display("FAIL midreset_count_nb: got %0d expected 0", n_count); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_x0;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234};
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++; if (b_d0 !== 32'd0) begin errors++; $display("FAIL x0_same_cycle: got %h expected 0", b_d0); end
    tick();
    idle();
    #1;
    checks++; if (b_d0 !== 32'd0) begin errors++; $display("FAIL x0_data: got %h expected 0", b_d0); end
    checks++; if (b_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", b_rd_busy[0]); end
    checks++; if (b_count !== 6'd0) begin errors++; $display("FAIL x0_count: got %0d expected 0", b_count); end
  endtask

  task automatic test_collision;
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11};
    rd_addr = {5'd0, 5'd3};
    #1;
    checks++; if (b_d0 !== 32'h22) begin errors++; $display("FAIL collide_bypass: got %h expected 22", b_d0); end
    checks++; if (n_d0 !== 32'h0) begin errors++; $display("FAIL collide_nobypass_same: got %h expected 0", n_d0); end
    tick();
    idle();
    #1;
    checks++; if (b_d0 !== 32'h22) begin errors++; $display("FAIL collide_stored: got %h expected 22", b_d0); end
    checks++; if (n_d0 !== 32'h22) begin errors++; $display("FAIL collide_stored_nb: got %h expected 22", n_d0); end
  endtask

  task automatic test_bypass_off;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h5};
    tick();
    wr_data = {32'h0, 32'hA};
    rd_addr = {5'd9, 5'd0};
    #1;
    checks++; if (n_d1 !== 32'h5) begin errors++; $display("FAIL nobypass_same: got %h expected 5", n_d1); end
    checks++; if (b_d1 !== 32'hA) begin errors++; $display("FAIL bypass_same: got %h expected a", b_d1); end
    tick();
    idle();
    #1;
    checks++; if (n_d1 !== 32'hA) begin errors++; $display("FAIL nobypass_next: got %h expected a", n_d1); end
  endtask

  task automatic test_scoreboard;
    iss_en = 1'b1; iss_addr = 5'd4;
    rd_addr = {5'd4, 5'd0};
    #1;
    checks++; if (b_rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_issue_same: got %b expected 0", b_rd_busy[1]); end
    tick();
    idle();
    #1;
    checks++; if (b_rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_busy: got %b expected 1", b_rd_busy[1]); end
    checks++; if (b_count !== 6'd1) begin errors++; $display("FAIL sb_count1: got %0d expected 1", b_count); end
    wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44, 32'h0};
    #1;
    checks++; if (b_rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_clear_bypass: got %b expected 0", b_rd_busy[1]); end
    checks++; if (n_rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_clear_nobypass: got %b expected 1", n_rd_busy[1]); end
    tick();
    idle();
    #1;
    checks++; if (b_count !== 6'd0) begin errors++; $display("FAIL sb_count0: got %0d expected 0", b_count); end
    checks++; if (n_rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_clear_nb_next: got %b expected 0", n_rd_busy[1]); end
    checks++; if (n_d1 !== 32'h44) begin errors++; $display("FAIL sb_data_nb: got %h expected 44", n_d1); end
  endtask

  task automatic test_set_clear;
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h66};
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    rd_addr = {5'd0, 5'd6};
    #1;
    checks++; if (b_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL setclr_busy: got %b expected 1", b_rd_busy[0]); end
    checks++; if (b_count !== 6'd1) begin errors++; $display("FAIL setclr_count: got %0d expected 1", b_count); end
    checks++; if (b_d0 !== 32'h66) begin errors++; $display("FAIL setclr_data: got %h expected 66", b_d0); end
    for (int r = 1; r < 32; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      tick();
    end
    idle();
    rd_addr = {5'd31, 5'd1};
    #1;
    checks++; if (b_count !== 6'd31) begin errors++; $display("FAIL all_busy_count: got %0d expected 31", b_count); end
    checks++; if (n_count !== 6'd31) begin errors++; $display("FAIL all_busy_count_nb: got %0d expected 31", n_count); end
    checks++; if (b_rd_busy !== 2'b11) begin errors++; $display("FAIL all_busy_ports: got %b expected 11", b_rd_busy); end
    wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'h2, 32'h1};
    tick();
    idle();
    #1;
    checks++; if (b_count !== 6'd29) begin errors++; $display("FAIL dual_clear_count: got %0d expected 29", b_count); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_collision();
    test_bypass_off();
    test_scoreboard();
    test_set_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
